cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
- Execution controller for the single-cycle ARM core and its data memory.
- Replaces the free-running divided clock: the whole system runs on the board clock `clk`. This block emits a one-cycle clock-enable `cpu_en` that gates state updates in arm, dmem and led_controller.
- Supported modes: free-run at a prescaled rate, debounced single-step from a push-button, and halt on a PC breakpoint.
- Also counts retired instructions for display and debug.

Parameters:
- TICK_DIV, 25_000_000: clk cycles between enables in RUN mode; must be >= 2.
- DEBOUNCE_CYCLES, 500_000: consecutive stable cycles required before the synchronized button level is accepted.
- ADDR_W, 32: width of the PC and breakpoint address.

Ports:
- clk  in  1  board clock (50 MHz).
- reset  in  1  synchronous reset, active-high.
- run_sw  in  1  level switch; 1 = request free-run.
- step_btn  in  1  raw asynchronous push-button, active-high.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  ADDR_W  breakpoint PC.
- pc  in  ADDR_W  current PC from arm.
- cpu_en  out  1  one-cycle enable; the instruction at pc retires on the clk edge that ends this cycle.
- halted  out  1  high in HALT or BREAK.
- state  out  2  current FSM state, for LEDs and debug.
- instr_count  out  32  number of cpu_en pulses since reset.

Behaviour:
- One clock domain. Reset is synchronous and active-high: all state changes only on posedge clk. step_btn is the only asynchronous input.
- Reset values:
  - state = HALT; cpu_en = 0; halted = 1; instr_count = 0.
  - Prescaler = 0; skip_bp = 0; synchronizer/debouncer flops and debounced level = 0.
- Button path:
  - 2-flop synchronizer.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
  - step_pulse is high for exactly one cycle on each debounced 0->1 edge.
  - Holding the button produces one pulse only.
- FSM states: HALT=0, RUN=1, STEP=2, BREAK=3.
- HALT:
  - If run_sw = 1: go to RUN, clear the prescaler, set skip_bp = 1.
  - Else if step_pulse: go to STEP.
  - If run_sw and step_pulse arrive in the same cycle, run wins and the pulse is dropped.
- STEP:
  - cpu_en = 1 for exactly this one cycle.
  - Next state is HALT unconditionally.
  - Breakpoints are not checked, so stepping always advances.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - In the cycle the prescaler equals TICK_DIV-1 (the tick cycle):
    - If bp_en && pc == bp_addr && !skip_bp: no enable; go to BREAK.
    - Otherwise: cpu_en = 1 in the next cycle; clear skip_bp.
  - First enable arrives TICK_DIV cycles after entering RUN.
  - run_sw = 0: go to HALT next cycle, clear the prescaler. An enable already scheduled for that cycle is still issued.
  - step_pulse is ignored.
- BREAK:
  - No enables.
  - run_sw = 0: go to HALT.
  - step_pulse: go to STEP, which executes the breakpoint instruction.
  - Staying with run_sw = 1 keeps BREAK; the user must toggle run_sw to resume.
- skip_bp exists so that resuming RUN at pc == bp_addr executes that instruction instead of re-breaking immediately.
- cpu_en is registered and never high in two consecutive cycles.
- instr_count increments by 1 in each cycle cpu_en = 1 and wraps from 0xFFFF_FFFF to 0.
- halted = (state == HALT || state == BREAK), registered together with state.
- Reset asserted mid-operation (any state, including a pending enable) overrides everything at the next edge. No enable is issued afterwards.

Decomposition:
- Package cpu_run_pkg holds:
  - Enum run_state_t (2 bits): RC_HALT, RC_RUN, RC_STEP, RC_BREAK.
  - Default constants RC_TICK_DIV and RC_DEBOUNCE.
- One sub-module, step_debouncer (parameter DEBOUNCE_CYCLES): ports clk, reset, btn_raw, btn_level, btn_pulse.
- The FSM, prescaler and counter live in cpu_run_ctrl.

Test Plan:
All scenarios use TICK_DIV=4 and DEBOUNCE_CYCLES=3. The bench PC model starts at 0 and adds 4 on each cpu_en.
1. Reset held 2 cycles, then idle 20 cycles with run_sw=0 -> state=0, halted=1, instr_count=0, cpu_en never high.
2. run_sw=1, bp_en=0 for 41 cycles -> cpu_en pulses every 4 cycles, first at cycle 4 after the HALT->RUN transition; 10 pulses total; instr_count=10.
3. step_btn high 10 cycles -> exactly one cpu_en, instr_count+1, state returns to 0. A separate 2-cycle glitch produces no pulse.
4. bp_en=1, bp_addr=0x10, run_sw=1 -> 4 enables (pc 0x0, 0x4, 0x8, 0xC). state=3 with pc=0x10, halted=1, instr_count=4, no further enables for 40 cycles.
5. From (4), step pulse -> one enable, pc=0x14, state=0. Then run_sw 0->1 with bp_addr=0x14 -> first tick executes (skip_bp), run continues.
6. Reset asserted while in RUN with prescaler=2 -> next cycle state=0, cpu_en=0, instr_count=0, no enable at the would-be tick.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// rtl/cpu_run_pkg.sv - shared state encoding and default timing constants for cpu_run_ctrl
package cpu_run_pkg;

  typedef enum logic [1:0] {
    RC_HALT  = 2'd0,
    RC_RUN   = 2'd1,
    RC_STEP  = 2'd2,
    RC_BREAK = 2'd3
  } run_state_t;

  localparam int RC_TICK_DIV = 25_000_000;
  localparam int RC_DEBOUNCE = 500_000;

endpackage

// File: rtl/step_debouncer.sv
// rtl/step_debouncer.sv - synchronizes and debounces the step push-button, emits one pulse per press
module step_debouncer
  import cpu_run_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = RC_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter runs only while the synchronized input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/breakpoint controller producing the core clock-enable
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int TICK_DIV        = RC_TICK_DIV,
  parameter int DEBOUNCE_CYCLES = RC_DEBOUNCE,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_en,
  output logic              halted,
  output logic [1:0]        state,
  output logic [31:0]       instr_count
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  run_state_t    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          skip_q, skip_d;
  logic          en_q, en_d;
  logic          halted_q;
  logic [31:0]   count_q;
  logic          step_level, step_pulse, step_go, bp_hit;

  step_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (step_btn),
    .btn_level(step_level),
    .btn_pulse(step_pulse)
  );

  assign step_go = step_pulse & step_level;
  assign bp_hit  = bp_en && (pc == bp_addr);

  // en_d is raised on the transition so that cpu_en is high while the new state is current.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    skip_d  = skip_q;
    en_d    = 1'b0;
    unique case (state_q)
      RC_HALT: begin
        if (run_sw) begin
          state_d = RC_RUN;
          presc_d = '0;
          skip_d  = 1'b1;
        end else if (step_go) begin
          state_d = RC_STEP;
          en_d    = 1'b1;
        end
      end
      RC_STEP: state_d = RC_HALT;
      RC_RUN: begin
        if (!run_sw) begin
          state_d = RC_HALT;
          presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (bp_hit && !skip_q) begin
            state_d = RC_BREAK;
          end else begin
            en_d   = 1'b1;
            skip_d = 1'b0;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      RC_BREAK: begin
        if (!run_sw) begin
          state_d = RC_HALT;
        end else if (step_go) begin
          state_d = RC_STEP;
          en_d    = 1'b1;
        end
      end
      default: state_d = RC_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RC_HALT;
      presc_q  <= '0;
      skip_q   <= 1'b0;
      en_q     <= 1'b0;
      halted_q <= 1'b1;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      skip_q   <= skip_d;
      en_q     <= en_d;
      halted_q <= (state_d == RC_HALT) || (state_d == RC_BREAK);
      count_q  <= count_q + 32'(en_q);
    end
  end

  assign cpu_en      = en_q;
  assign halted      = halted_q;
  assign state       = state_q;
  assign instr_count = count_q;

endmodule
